flow_ctrl: RTL and testbench
============================

# flow_ctrl

Pipeline flow controller driving the `fc_*` flush and stall inputs of the IF/ID and ID/EX pipeline registers, plus the PC redirect to the fetch stage. It arbitrates branch flushes from EX, jump flushes from ID, load-use interlocks and D-cache miss stalls, and tracks each miss with a small state machine and timeout counter. Optional performance counters report stall and flush activity.

## Interface
- `DC_TIMEOUT`, default 255: miss-wait cycles before the timeout flag sets; range 1..65535.
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `ex_btype_taken_i`  in  1  branch in EX resolved taken
- `ex_btype_jump_pc_i`  in  32  branch target
- `id_jtype_flag_i`  in  1  JAL/JALR decoded in ID
- `id_jtype_jump_pc_i`  in  32  jump target
- `ex_mtype_i`  in  1  EX holds a memory op
- `ex_mem_rw_i`  in  1  0 = load, 1 = store
- `ex_reg_waddr_i`  in  5  EX destination register
- `id_rs1_raddr_i`, `id_rs2_raddr_i`  in  5 each  ID source registers
- `id_rs1_re_i`, `id_rs2_re_i`  in  1 each  source actually read
- `dcache_miss_i`  in  1  MEM access missed, level while unresolved
- `dcache_ready_i`  in  1  refill complete, one-cycle pulse
- `fc_flush_btype_flag_o`  out  1  flush IF/ID and ID/EX
- `fc_flush_jtype_flag_o`  out  1  flush IF/ID only
- `fc_Dcache_stall_flag_o`  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- `fc_load_use_stall_o`  out  1  hold PC and IF/ID, bubble ID/EX
- `fc_jump_flag_o`  out  1  redirect PC this cycle
- `fc_jump_pc_o`  out  32  redirect target
- `fc_dcache_timeout_o`  out  1  sticky timeout error
- `fc_stall_cnt_o`, `fc_flush_cnt_o`  out  32 each  perf counters

## Operation
- FSM states: IDLE, MISS. Encoding is free.
- IDLE to MISS when `dcache_miss_i`=1. MISS to IDLE when `dcache_ready_i`=1. `dcache_ready_i` in IDLE is ignored.
- Stall: `fc_Dcache_stall_flag_o` = (IDLE & `dcache_miss_i`) | (MISS & ~`dcache_ready_i`).
  - Stall rises in the same cycle as the miss.
  - Stall falls in the same cycle as the ready pulse.
- Timeout counter (16-bit):
  - Clears on IDLE to MISS and increments each MISS cycle.
  - When it reaches `DC_TIMEOUT`, `fc_dcache_timeout_o` sets and stays set until reset.
  - Stall continues regardless; the counter saturates.
- Flush suppression: every flush and redirect is forced 0 while the D-cache stall is active.
  - The branch or jump is held in its stage and re-evaluated on the first unstalled cycle, so each redirect fires exactly once.
- Branch flush: `fc_flush_btype_flag_o` = `ex_btype_taken_i` & ~stall.
- Load-use hazard, defined as all of:
  - `ex_mtype_i` & ~`ex_mem_rw_i` & `ex_reg_waddr_i`≠0,
  - and (`id_rs1_re_i` & rs1 = waddr) | (`id_rs2_re_i` & rs2 = waddr).
- `fc_load_use_stall_o` = hazard & ~stall & ~btype flush. A btype flush kills the dependent instruction.
- Jump flush: `fc_flush_jtype_flag_o` = `id_jtype_flag_i` & ~stall & ~btype flush & ~load-use stall. A JALR waits out its interlock.
- Redirect:
  - `fc_jump_flag_o` = btype flush | jtype flush.
  - `fc_jump_pc_o` = `ex_btype_jump_pc_i` if btype flush, else `id_jtype_jump_pc_i` if jtype flush, else 0.
  - EX (older) beats ID.
- Reset (`rst_n`=0 at a rising edge):
  - FSM returns to IDLE; timeout counter, timeout flag and perf counters clear.
  - All combinational outputs are forced 0 while `rst_n`=0.
  - Reset mid-miss abandons the miss; a still-high `dcache_miss_i` after reset re-enters MISS.

## Timing
- Flush, stall and redirect outputs are combinational from inputs and state, with zero-cycle latency.
- Only the FSM, counters and timeout flag are registered.
- Simultaneous `dcache_miss_i` and `ex_btype_taken_i` in IDLE: stall=1, flush=0, jump=0.
- Simultaneous btype and jtype: btype only. The jump instruction is flushed.
- Ready pulse in the cycle a new miss arrives in MISS: go to IDLE, stall=0 that cycle. The next cycle re-enters MISS if the miss is still high.

## Configuration
- `FC_PERF_CNT_EN` defined:
  - `fc_stall_cnt_o` increments each cycle the D-cache stall is active.
  - `fc_flush_cnt_o` increments each cycle either flush is asserted.
  - Both are 32-bit, wrap at 2^32, and clear on reset.
- `FC_PERF_CNT_EN` undefined: both ports tied to 32'h0 and no counter flops are instantiated. Ports always exist.

## Test plan
- `ex_btype_taken_i`=1, target 32'h0000_0100, no stall -> btype flush=1, `fc_jump_flag_o`=1, `fc_jump_pc_o`=32'h100 in the same cycle.
- `dcache_miss_i` high 5 cycles, ready pulsed on the 5th, `ex_btype_taken_i` high throughout -> stall 1 for cycles 1-4 with flush=0; in cycle 5 stall=0 and flush=1; `fc_stall_cnt_o`=4 with `FC_PERF_CNT_EN`.
- EX load to x5; ID reads rs2=x5 with `id_jtype_flag_i`=1 (JALR) -> load_use=1, jtype flush=0. Next cycle, with EX no longer a load -> jtype flush=1, jump pc = ID target.
- `DC_TIMEOUT`=4, miss held with no ready for 10 cycles -> `fc_dcache_timeout_o` rises after the 4th MISS cycle, stays 1, stall stays 1. Then apply reset -> flag 0, state IDLE.
- Btype and jtype in the same cycle, targets 32'h200 and 32'h300 -> only btype flush asserted, `fc_jump_pc_o`=32'h200. Load to x0 with a matching rs1 -> no load-use stall.

Source files
------------

// File: rtl/flow_ctrl.sv
// Pipeline flow controller: branch/jump flush, load-use and D-cache stall.
// Optional perf counters enabled by defining FC_PERF_CNT_EN.
module flow_ctrl #(
  parameter int unsigned DC_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_btype_taken_i,
  input  logic [31:0] ex_btype_jump_pc_i,
  input  logic        id_jtype_flag_i,
  input  logic [31:0] id_jtype_jump_pc_i,
  input  logic        ex_mtype_i,
  input  logic        ex_mem_rw_i,
  input  logic [4:0]  ex_reg_waddr_i,
  input  logic [4:0]  id_rs1_raddr_i,
  input  logic [4:0]  id_rs2_raddr_i,
  input  logic        id_rs1_re_i,
  input  logic        id_rs2_re_i,
  input  logic        dcache_miss_i,
  input  logic        dcache_ready_i,
  output logic        fc_flush_btype_flag_o,
  output logic        fc_flush_jtype_flag_o,
  output logic        fc_Dcache_stall_flag_o,
  output logic        fc_load_use_stall_o,
  output logic        fc_jump_flag_o,
  output logic [31:0] fc_jump_pc_o,
  output logic        fc_dcache_timeout_o,
  output logic [31:0] fc_stall_cnt_o,
  output logic [31:0] fc_flush_cnt_o
);

  typedef enum logic {
    S_IDLE,
    S_MISS
  } state_t;

  localparam logic [16:0] TO_LIM = 17'(DC_TIMEOUT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_to_cnt;
  logic        r_to_flag;
  logic [16:0] w_cnt_inc;
  logic        w_stall;
  logic        w_bflush;
  logic        w_hazard;
  logic        w_lu;
  logic        w_jflush;

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_stall = dcache_miss_i;
        if (dcache_miss_i) w_state_nxt = S_MISS;
      end
      S_MISS: begin
        w_stall = ~dcache_ready_i;
        if (dcache_ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // outputs held low while reset is asserted
    w_stall = w_stall & rst_n;
  end

  always_comb begin
    w_hazard = ex_mtype_i & ~ex_mem_rw_i
             & (ex_reg_waddr_i != 5'd0)
             & ((id_rs1_re_i & (id_rs1_raddr_i == ex_reg_waddr_i))
             | (id_rs2_re_i & (id_rs2_raddr_i == ex_reg_waddr_i)));
    w_bflush = rst_n & ex_btype_taken_i & ~w_stall;
    w_lu     = rst_n & w_hazard & ~w_stall & ~w_bflush;
    w_jflush = rst_n & id_jtype_flag_i & ~w_stall
             & ~w_bflush & ~w_lu;
  end

  assign w_cnt_inc = {1'b0, r_to_cnt} + 17'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_to_cnt  <= 16'd0;
      r_to_flag <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_state_nxt == S_MISS) begin
        r_to_cnt <= 16'd0;
      end else if (r_state == S_MISS && r_to_cnt != 16'hFFFF) begin
        r_to_cnt <= w_cnt_inc[15:0];
      end
      if (r_state == S_MISS && w_cnt_inc >= TO_LIM) begin
        r_to_flag <= 1'b1;
      end
    end
  end

  assign fc_flush_btype_flag_o  = w_bflush;
  assign fc_flush_jtype_flag_o  = w_jflush;
  assign fc_Dcache_stall_flag_o = w_stall;
  assign fc_load_use_stall_o    = w_lu;
  assign fc_jump_flag_o         = w_bflush | w_jflush;
  assign fc_jump_pc_o = w_bflush ? ex_btype_jump_pc_i
                      : w_jflush ? id_jtype_jump_pc_i
                      : 32'h0;
  assign fc_dcache_timeout_o    = r_to_flag;

`ifdef FC_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_bflush | w_jflush) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign fc_stall_cnt_o = r_stall_cnt;
  assign fc_flush_cnt_o = r_flush_cnt;
`else
  assign fc_stall_cnt_o = 32'h0;
  assign fc_flush_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_flow_ctrl.sv
// Randomized self-checking bench for flow_ctrl against a behavioural model.
// Directed scenarios first, then random traffic.
module tb_flow_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        taken;
  logic [31:0] bpc;
  logic        jflag;
  logic [31:0] jpc;
  logic        mtype;
  logic        rw;
  logic [4:0]  waddr;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        re1;
  logic        re2;
  logic        miss;
  logic        ready;
  logic        o_bf;
  logic        o_jf;
  logic        o_st;
  logic        o_lu;
  logic        o_jmp;
  logic [31:0] o_pc;
  logic        o_to;
  logic [31:0] o_sc;
  logic [31:0] o_fc;

  int n_chk = 0;
  int n_err = 0;

  bit          m_in_miss;
  int unsigned m_mc;
  bit          m_to;
  logic [31:0] m_sc;
  logic [31:0] m_fc;

  bit          e_st;
  bit          e_bf;
  bit          e_lu;
  bit          e_jf;
  logic [31:0] e_pc;

  flow_ctrl #(.DC_TIMEOUT(TO)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .ex_btype_taken_i       (taken),
    .ex_btype_jump_pc_i     (bpc),
    .id_jtype_flag_i        (jflag),
    .id_jtype_jump_pc_i     (jpc),
    .ex_mtype_i             (mtype),
    .ex_mem_rw_i            (rw),
    .ex_reg_waddr_i         (waddr),
    .id_rs1_raddr_i         (rs1),
    .id_rs2_raddr_i         (rs2),
    .id_rs1_re_i            (re1),
    .id_rs2_re_i            (re2),
    .dcache_miss_i          (miss),
    .dcache_ready_i         (ready),
    .fc_flush_btype_flag_o  (o_bf),
    .fc_flush_jtype_flag_o  (o_jf),
    .fc_Dcache_stall_flag_o (o_st),
    .fc_load_use_stall_o    (o_lu),
    .fc_jump_flag_o         (o_jmp),
    .fc_jump_pc_o           (o_pc),
    .fc_dcache_timeout_o    (o_to),
    .fc_stall_cnt_o         (o_sc),
    .fc_flush_cnt_o         (o_fc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic calc();
    bit haz;
    e_st = rst_n && (m_in_miss ? !ready : miss);
    e_bf = rst_n && taken && !e_st;
    haz  = mtype && !rw && waddr != 0 &&
           ((re1 && rs1 == waddr) || (re2 && rs2 == waddr));
    e_lu = rst_n && haz && !e_st && !e_bf;
    e_jf = rst_n && jflag && !e_st && !e_bf && !e_lu;
    e_pc = e_bf ? bpc : (e_jf ? jpc : 32'h0);
  endtask

  task automatic settle();
    logic [31:0] xs;
    logic [31:0] xf;
    @(negedge clk);
    calc();
`ifdef FC_PERF_CNT_EN
    xs = m_sc;
    xf = m_fc;
`else
    xs = 32'h0;
    xf = 32'h0;
`endif
    chk("stall", 32'(o_st), 32'(e_st));
    chk("bflush", 32'(o_bf), 32'(e_bf));
    chk("loaduse", 32'(o_lu), 32'(e_lu));
    chk("jflush", 32'(o_jf), 32'(e_jf));
    chk("jump", 32'(o_jmp), 32'(e_bf | e_jf));
    chk("jump_pc", o_pc, e_pc);
    chk("timeout", 32'(o_to), 32'(m_to));
    chk("stall_cnt", o_sc, xs);
    chk("flush_cnt", o_fc, xf);
  endtask

  task automatic adv();
    @(posedge clk);
    if (!rst_n) begin
      m_in_miss = 0;
      m_mc      = 0;
      m_to      = 0;
      m_sc      = 0;
      m_fc      = 0;
    end else begin
      if (e_st) m_sc = m_sc + 1;
      if (e_bf || e_jf) m_fc = m_fc + 1;
      if (!m_in_miss) begin
        if (miss) begin
          m_in_miss = 1;
          m_mc      = 0;
        end
      end else begin
        m_mc = (m_mc + 1 > 65535) ? 65535 : m_mc + 1;
        if (m_mc >= TO) m_to = 1;
        if (ready) m_in_miss = 0;
      end
    end
    #1;
  endtask

  task automatic quiet();
    rst_n = 1;
    taken = 0; bpc = 0;
    jflag = 0; jpc = 0;
    mtype = 0; rw = 0; waddr = 0;
    rs1 = 0; rs2 = 0; re1 = 0; re2 = 0;
    miss = 0; ready = 0;
  endtask

  task automatic do_reset();
    quiet();
    rst_n = 0;
    settle();
    adv();
    rst_n = 1;
  endtask

  initial begin
    m_in_miss = 0; m_mc = 0; m_to = 0;
    m_sc = 0; m_fc = 0;
    quiet();
    #1;
    do_reset();
    do_reset();
    settle();
    chk("rst_to", 32'(o_to), 32'h0);
    adv();

    // branch taken, no stall
    taken = 1; bpc = 32'h100;
    settle();
    chk("tp1_pc", o_pc, 32'h100);
    chk("tp1_bf", 32'(o_bf), 32'h1);
    adv();
    do_reset();

    // five-cycle miss with branch waiting
    taken = 1; bpc = 32'h180; miss = 1;
    for (int i = 1; i <= 5; i++) begin
      ready = (i == 5);
      settle();
      chk("tp2_st", 32'(o_st), (i < 5) ? 32'h1 : 32'h0);
      chk("tp2_bf", 32'(o_bf), (i < 5) ? 32'h0 : 32'h1);
      adv();
    end
    quiet();
    settle();
`ifdef FC_PERF_CNT_EN
    chk("tp2_sc", o_sc, 32'd4);
`endif
    adv();
    do_reset();

    // JALR behind a load-use interlock
    mtype = 1; rw = 0; waddr = 5'd5;
    rs2 = 5'd5; re2 = 1;
    jflag = 1; jpc = 32'h400;
    settle();
    chk("tp3_lu", 32'(o_lu), 32'h1);
    chk("tp3_jf0", 32'(o_jf), 32'h0);
    adv();
    mtype = 0;
    settle();
    chk("tp3_jf1", 32'(o_jf), 32'h1);
    chk("tp3_pc", o_pc, 32'h400);
    adv();
    do_reset();

    // timeout after DC_TIMEOUT miss cycles
    miss = 1;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("tp4_to", 32'(o_to), (i >= 5) ? 32'h1 : 32'h0);
      adv();
    end
    settle();
    chk("tp4_st", 32'(o_st), 32'h1);
    adv();
    do_reset();
    settle();
    chk("tp4_rto", 32'(o_to), 32'h0);
    chk("tp4_idle", 32'(o_st), 32'h0);
    adv();

    // btype beats jtype; load to x0 is no hazard
    taken = 1; bpc = 32'h200;
    jflag = 1; jpc = 32'h300;
    settle();
    chk("tp5_jf", 32'(o_jf), 32'h0);
    chk("tp5_pc", o_pc, 32'h200);
    adv();
    quiet();
    mtype = 1; waddr = 0; rs1 = 0; re1 = 1;
    settle();
    chk("tp5_lu", 32'(o_lu), 32'h0);
    adv();

    // random traffic
    quiet();
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 7) == 0) miss = ~miss;
      ready = ($urandom_range(0, 3) == 0);
      taken = ($urandom_range(0, 3) == 0);
      jflag = ($urandom_range(0, 3) == 0);
      bpc   = $urandom;
      jpc   = $urandom;
      mtype = $urandom_range(0, 1) == 1;
      rw    = $urandom_range(0, 1) == 1;
      waddr = 5'($urandom_range(0, 3));
      rs1   = 5'($urandom_range(0, 3));
      rs2   = 5'($urandom_range(0, 3));
      re1   = $urandom_range(0, 1) == 1;
      re2   = $urandom_range(0, 1) == 1;
      settle();
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
